// File: rtl/bus_interconnect.sv
// Multi-master / multi-slave single-transaction bus interconnect.
// One master is granted at a time. Its request is routed to the slave whose
// masked base address matches, and the slave's completion is reflected back.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; arbitrate among requesting masters
// BUSY  | granted master routed to decoded slave; waiting for slave ready
// ERR   | one-cycle error completion to the granted master (unmapped/timeout)
module bus_interconnect #(
   parameter int                      NMASTERS   = 3,
   parameter int                      NSLAVES    = 3,
   parameter logic [NSLAVES*32-1:0]   MATCH_ADDR = {32'h1100_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NSLAVES*32-1:0]   MATCH_MASK = {32'hFFFF_FFF8, 32'hFFFF_FFE0, 32'hFFFF_0000},
   parameter int                      ARB_MODE   = 1,
   parameter int                      TIMEOUT    = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [32*NMASTERS-1:0] master_address,
   input  logic [32*NMASTERS-1:0] master_data_i,
   input  logic [4*NMASTERS-1:0]  master_wr,
   input  logic [NMASTERS-1:0]    master_enable,
   output logic [31:0]            master_data_o,
   output logic [NMASTERS-1:0]    master_ready,
   output logic [NMASTERS-1:0]    master_error,
   input  logic [32*NSLAVES-1:0]  slave_data_i,
   input  logic [NSLAVES-1:0]     slave_ready,
   output logic [31:0]            slave_address,
   output logic [31:0]            slave_data_o,
   output logic [3:0]             slave_wr,
   output logic [NSLAVES-1:0]     slave_enable
);

   localparam int MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

   state_t        state_q;
   logic [MW-1:0] grant_q;
   logic [MW-1:0] last_q;
   logic [15:0]   wait_q;

   logic [MW-1:0] arb_idx;
   logic          arb_any;
   logic [31:0]   g_addr;
   logic [31:0]   g_wdata;
   logic [3:0]    g_wr;
   logic          g_en;
   logic          dec_hit;
   logic [SW-1:0] dec_idx;
   logic          sel_ready;
   logic [31:0]   sel_data;
   logic          busy;
   logic          busy_act;
   logic          complete;

   // Pick the winner: lowest index, or rotating start after the last grant.
   always_comb begin
      int cand;
      cand    = 0;
      arb_idx = '0;
      arb_any = 1'b0;
      for (int i = 0; i < NMASTERS; i++) begin
         if (ARB_MODE == 0) cand = i;
         else               cand = (int'(last_q) + 1 + i) % NMASTERS;
         if (!arb_any && master_enable[cand]) begin
            arb_any = 1'b1;
            arb_idx = MW'(cand);
         end
      end
   end

   // Mux out the granted master's request.
   always_comb begin
      g_addr  = '0;
      g_wdata = '0;
      g_wr    = '0;
      g_en    = 1'b0;
      for (int i = 0; i < NMASTERS; i++) begin
         if (grant_q == MW'(i)) begin
            g_addr  = master_address[32*i +: 32];
            g_wdata = master_data_i[32*i +: 32];
            g_wr    = master_wr[4*i +: 4];
            g_en    = master_enable[i];
         end
      end
   end

   // Address decode; overlapping windows resolve to the lowest slave index.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int s = 0; s < NSLAVES; s++) begin
         if (!dec_hit && ((g_addr & MATCH_MASK[32*s +: 32]) == MATCH_ADDR[32*s +: 32])) begin
            dec_hit = 1'b1;
            dec_idx = SW'(s);
         end
      end
   end

   // Only the decoded slave's ready and data are looked at.
   always_comb begin
      sel_ready = 1'b0;
      sel_data  = '0;
      for (int s = 0; s < NSLAVES; s++) begin
         if (dec_idx == SW'(s)) begin
            sel_ready = slave_ready[s];
            sel_data  = slave_data_i[32*s +: 32];
         end
      end
   end

   assign busy     = (state_q == BUSY) && !rst;
   assign busy_act = busy && g_en && dec_hit;
   assign complete = busy_act && sel_ready;

   // Slave-side request path and master-side completion, all combinational.
   always_comb begin
      slave_address = '0;
      slave_data_o  = '0;
      slave_wr      = '0;
      slave_enable  = '0;
      master_ready  = '0;
      master_error  = '0;
      master_data_o = '0;
      if (busy) begin
         slave_address = g_addr;
         slave_data_o  = g_wdata;
         slave_wr      = g_wr;
      end
      for (int s = 0; s < NSLAVES; s++) begin
         if (busy_act && dec_idx == SW'(s)) slave_enable[s] = 1'b1;
      end
      for (int i = 0; i < NMASTERS; i++) begin
         if (grant_q == MW'(i)) begin
            master_ready[i] = complete;
            master_error[i] = (state_q == ERR) && !rst;
         end
      end
      if (complete && g_wr == 4'h0) master_data_o = sel_data;
   end

   // Transaction sequencer: grant, wait for ready with timeout, report error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= MW'(NMASTERS - 1);
         wait_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_any) begin
                  grant_q <= arb_idx;
                  last_q  <= arb_idx;
                  wait_q  <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!g_en) begin
                  state_q <= IDLE;
               end else if (!dec_hit) begin
                  state_q <= ERR;
               end else if (sel_ready) begin
                  state_q <= IDLE;
               end else begin
                  // Reaching TIMEOUT waits ends the access; enable drops with the state change.
                  wait_q <= wait_q + 16'd1;
                  if (wait_q == 16'(TIMEOUT - 1)) state_q <= ERR;
               end
            end
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_interconnect.sv
`timescale 1ns/1ps
module tb_bus_interconnect;
   localparam int NM  = 3;
   localparam int NS  = 3;
   localparam int TMO = 4;
   localparam logic [NS*32-1:0] M_ADDR = {32'h1100_0000, 32'h1000_0000, 32'h0000_0000};
   // Slave 1 window also covers 0x1100_0000..1F, overlapping slave 2.
   localparam logic [NS*32-1:0] M_MASK = {32'hFFFF_FF00, 32'hFEFF_FFE0, 32'hFFFF_0000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [32*NM-1:0]  master_address, master_data_i;
   logic [4*NM-1:0]   master_wr;
   logic [NM-1:0]     master_enable;
   logic [31:0]       master_data_o;
   logic [NM-1:0]     master_ready, master_error;
   logic [32*NS-1:0]  slave_data_i;
   logic [NS-1:0]     slave_ready;
   logic [31:0]       slave_address, slave_data_o;
   logic [3:0]        slave_wr;
   logic [NS-1:0]     slave_enable;

   logic [32*NM-1:0]  fp_address, fp_wdata;
   logic [4*NM-1:0]   fp_wr;
   logic [NM-1:0]     fp_enable;
   logic [31:0]       fp_rdata;
   logic [NM-1:0]     fp_ready, fp_error;
   logic [32*NS-1:0]  fp_sdata;
   logic [NS-1:0]     fp_sready;
   logic [31:0]       fp_saddr, fp_swdata;
   logic [3:0]        fp_swr;
   logic [NS-1:0]     fp_senable;

   bus_interconnect #(.NMASTERS(NM), .NSLAVES(NS), .MATCH_ADDR(M_ADDR), .MATCH_MASK(M_MASK),
                      .ARB_MODE(1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .master_address(master_address), .master_data_i(master_data_i), .master_wr(master_wr),
      .master_enable(master_enable), .master_data_o(master_data_o), .master_ready(master_ready),
      .master_error(master_error), .slave_data_i(slave_data_i), .slave_ready(slave_ready),
      .slave_address(slave_address), .slave_data_o(slave_data_o), .slave_wr(slave_wr),
      .slave_enable(slave_enable));

   bus_interconnect #(.ARB_MODE(0)) dut_fp (
      .clk(clk), .rst(rst),
      .master_address(fp_address), .master_data_i(fp_wdata), .master_wr(fp_wr),
      .master_enable(fp_enable), .master_data_o(fp_rdata), .master_ready(fp_ready),
      .master_error(fp_error), .slave_data_i(fp_sdata), .slave_ready(fp_sready),
      .slave_address(fp_saddr), .slave_data_o(fp_swdata), .slave_wr(fp_swr),
      .slave_enable(fp_senable));

   typedef struct packed {
      logic [7:0]  m;
      logic        is_err;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          req_en   [NM];
   logic [31:0] req_addr [NM];
   logic [31:0] req_data [NM];
   logic [3:0]  req_wr   [NM];
   logic [31:0] slv_data [NS];
   int          last_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      for (int s = 0; s < NS; s++)
         if ((a & M_MASK[32*s +: 32]) == M_ADDR[32*s +: 32]) return s;
      return -1;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom % 5)
         0:       return {16'h0000, 16'($urandom)};
         1:       return 32'h1000_0000 | 32'($urandom % 32);
         2:       return 32'h1100_0000 | 32'($urandom % 256);
         3:       return 32'h1000_0000 | 32'($urandom % 64);
         default: return $urandom;
      endcase
   endfunction

   task automatic apply_bus();
      for (int m = 0; m < NM; m++) begin
         master_enable[m]            = req_en[m];
         master_address[32*m +: 32]  = req_addr[m];
         master_data_i[32*m +: 32]   = req_data[m];
         master_wr[4*m +: 4]         = req_wr[m];
      end
      for (int s = 0; s < NS; s++) slave_data_i[32*s +: 32] = slv_data[s];
   endtask

   task automatic set_req(input int m, input logic [31:0] a, input logic [3:0] wr);
      req_en[m]   = 1'b1;
      req_addr[m] = a;
      req_data[m] = $urandom;
      req_wr[m]   = wr;
   endtask

   task automatic rand_req(input int m);
      set_req(m, rand_addr(), ($urandom % 2) ? 4'(($urandom % 15) + 1) : 4'h0);
   endtask

   // One arbitration + transaction. Entered and left in an IDLE cycle, #1 after posedge.
   // lat: BUSY cycles before the target slave raises ready. abort_at>0: master drops enable in that BUSY cycle.
   task automatic do_txn(input int lat, input int abort_at);
      int          w, ts, se_end, exp_cyc, cand;
      bit          done, abort;
      exp_t        e;
      logic [NS-1:0] exp_se, rdy;
      w = -1;
      for (int i = 1; i <= NM; i++) begin
         cand = (last_m + i) % NM;
         if (w < 0 && req_en[cand]) w = cand;
      end
      if (w < 0) begin
         checks++; errors++;
         $display("FAIL no_pending_request");
         return;
      end
      last_m  = w;
      ts      = decode(req_addr[w]);
      abort   = (abort_at > 0) && (ts >= 0);
      e.m     = 8'(w);
      e.data  = '0;
      if (ts < 0) begin
         e.is_err = 1'b1; exp_cyc = 2; se_end = 0;
      end else if (lat < TMO) begin
         e.is_err = 1'b0; exp_cyc = lat + 1; se_end = lat + 2;
         if (req_wr[w] == 4'h0) e.data = slv_data[ts];
      end else begin
         e.is_err = 1'b1; exp_cyc = TMO + 1; se_end = TMO + 1;
      end
      if (abort) se_end = abort_at;
      else       exp_q.push_back(e);
      apply_bus();
      done = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(posedge clk); #1;
         if (abort && k == abort_at) begin
            req_en[w] = 1'b0;
            apply_bus();
         end
         rdy = NS'($urandom);
         if (ts >= 0) rdy[ts] = (k - 1 >= lat);
         slave_ready = rdy;
         @(negedge clk);
         exp_se = '0;
         if (ts >= 0 && k < se_end) exp_se[ts] = 1'b1;
         chk("slave_enable", 32'(slave_enable), 32'(exp_se));
         if (exp_se != 0) begin
            chk("slave_address", slave_address, req_addr[w]);
            chk("slave_wdata", slave_data_o, req_data[w]);
            chk("slave_wr", 32'(slave_wr), 32'(req_wr[w]));
         end
         if (abort) begin
            if (k == abort_at) done = 1'b1;
         end else if ((master_ready | master_error) != 0) begin
            done = 1'b1;
            chk("completion_cycle", k, exp_cyc);
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL txn_timeout master=%0d", w);
      end
      @(posedge clk); #1;
      slave_ready = '0;
      req_en[w]   = 1'b0;
      apply_bus();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_slave_enable"}, 32'(slave_enable), 0);
      chk({tag, "_master_ready"}, 32'(master_ready), 0);
      chk({tag, "_master_error"}, 32'(master_error), 0);
      chk({tag, "_master_data_o"}, master_data_o, 0);
   endtask

   // Scoreboard monitor: every completion pulse pops one expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if ((master_ready | master_error) != 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 32'(master_ready | master_error), 0);
            end else begin
               e = exp_q.pop_front();
               chk("master_ready", 32'(master_ready), e.is_err ? 32'h0 : 32'(1) << e.m);
               chk("master_error", 32'(master_error), e.is_err ? 32'(1) << e.m : 32'h0);
               chk("master_data_o", master_data_o, e.data);
            end
         end else begin
            chk("idle_data_o", master_data_o, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      int fp_cnt;
      rst = 1'b1;
      last_m = NM - 1;
      for (int m = 0; m < NM; m++) begin
         req_en[m] = 1'b0; req_addr[m] = '0; req_data[m] = '0; req_wr[m] = '0;
      end
      for (int s = 0; s < NS; s++) slv_data[s] = '0;
      slave_ready = '0;
      apply_bus();
      fp_address = '0; fp_wdata = '0; fp_wr = '0; fp_enable = '1;
      fp_sdata = '0; fp_sready = '1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      chk("reset_slave_address", slave_address, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Fixed priority, all masters requesting, slave always ready: M0 every other cycle.
      fp_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if ((fp_ready | fp_error) != 0) begin
            fp_cnt++;
            chk("fp_grant", 32'(fp_ready), 32'h1);
         end
      end
      chk("fp_grant_count", fp_cnt, 6);
      @(posedge clk); #1;

      // Round-robin with all masters requesting continuously.
      for (int r = 0; r < 4; r++) begin
         for (int m = 0; m < NM; m++) set_req(m, 32'h0000_0040 + 32'(m * 4), 4'h0);
         for (int s = 0; s < NS; s++) slv_data[s] = $urandom;
         do_txn(0, 0);
      end
      for (int m = 0; m < NM; m++) req_en[m] = 1'b0;

      // Single read with two wait cycles.
      set_req(0, 32'h0000_0010, 4'h0);
      slv_data[0] = 32'hCAFE_F00D;
      do_txn(2, 0);

      // Unmapped write.
      set_req(1, 32'h2000_0000, 4'hF);
      do_txn(0, 0);

      // Timeout on a silent slave.
      set_req(0, 32'h1000_0004, 4'h0);
      do_txn(99, 0);

      // Overlapping windows: slave 1 wins over slave 2.
      set_req(2, 32'h1100_0000, 4'h0);
      slv_data[1] = 32'h1234_5678;
      slv_data[2] = 32'h8765_4321;
      do_txn(1, 0);

      // Write completion returns zero read data.
      set_req(1, 32'h1100_0040, 4'h3);
      do_txn(0, 0);

      // Abort by the granted master.
      set_req(2, 32'h0000_0020, 4'h0);
      do_txn(99, 2);

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         bit any;
         for (int m = 0; m < NM; m++)
            if (!req_en[m] && ($urandom % 2 == 1)) rand_req(m);
         any = 1'b0;
         for (int m = 0; m < NM; m++) any |= req_en[m];
         if (!any) rand_req(int'($urandom % NM));
         for (int s = 0; s < NS; s++) slv_data[s] = $urandom;
         if ($urandom % 8 == 0) do_txn(99, 1 + int'($urandom % 3));
         else                   do_txn(int'($urandom % 6), 0);
      end

      // Reset in the middle of a transaction.
      for (int m = 0; m < NM; m++) req_en[m] = 1'b0;
      set_req(0, 32'h0000_0100, 4'h0);
      slave_ready = '0;
      apply_bus();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midrst");
      @(posedge clk); #1;
      @(negedge clk);
      chk_all_zero("midrst_next");
      @(posedge clk); #1;
      rst = 1'b0;
      last_m = NM - 1;
      req_en[0] = 1'b0;
      set_req(1, 32'h1000_0008, 4'h0);
      slv_data[1] = 32'h0BAD_BEEF;
      do_txn(1, 0);

      repeat (5) @(posedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 Parameter NMASTERS, default 3, number of bus masters (1..8).
REQ-002 Parameter NSLAVES, default 3, number of slaves (1..8).
REQ-003 Parameter MATCH_ADDR, default {32'h1100_0000, 32'h1000_0000, 32'h0000_0000}, per-slave base address (NSLAVES x 32, slave 0 in LSBs).
REQ-004 Parameter MATCH_MASK, default {32'hFFFF_FFF8, 32'hFFFF_FFE0, 32'hFFFF_0000}, per-slave address mask (NSLAVES x 32).
REQ-005 Parameter ARB_MODE, default 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 Parameter TIMEOUT, default 255, maximum wait cycles for slave ready (1..65535).
REQ-007 clk  input  1  bus clock; single clock domain.
REQ-008 rst  input  1  reset; synchronous and active-high.
REQ-009 master_address  input  32*NMASTERS  per-master address.
REQ-010 master_data_i  input  32*NMASTERS  per-master write data.
REQ-011 master_wr  input  4*NMASTERS  per-master byte write enables (0000 = read).
REQ-012 master_enable  input  NMASTERS  per-master request, held until ready or error.
REQ-013 master_data_o  output  32  read data, shared by all masters.
REQ-014 master_ready  output  NMASTERS  per-master one-cycle completion.
REQ-015 master_error  output  NMASTERS  per-master one-cycle error completion.
REQ-016 slave_data_i  input  32*NSLAVES  per-slave read data.
REQ-017 slave_ready  input  NSLAVES  per-slave completion.
REQ-018 slave_address, slave_data_o, slave_wr  output  32, 32, 4  shared slave-side request.
REQ-019 slave_enable  output  NSLAVES  one-hot slave select.

Function
REQ-020 The FSM SHALL have the states IDLE, BUSY and ERR.
REQ-021 IDLE: when any master_enable is high, the block SHALL register the winner index and move to BUSY on the next edge; otherwise it SHALL stay in IDLE.
REQ-022 In ARB_MODE 0, the winner SHALL be the lowest-index requesting master.
REQ-023 In ARB_MODE 1, the search SHALL start at (last granted index + 1) mod NMASTERS; the last granted index SHALL reset to NMASTERS-1.
REQ-024 In BUSY, slave_address, slave_data_o and slave_wr SHALL be the granted master's signals, combinational.
REQ-025 Decode: slave s matches when (address & MATCH_MASK[s]) == MATCH_ADDR[s]; on multiple matches, the lowest index SHALL win.
REQ-026 In BUSY, slave_enable SHALL assert only the matched slave, and only while the granted master_enable is high.
REQ-027 In BUSY with no slave matching, the block SHALL go to ERR with no slave_enable asserted.
REQ-028 ERR SHALL pulse master_error[granted] for exactly one cycle, then return to IDLE.
REQ-029 In BUSY, when the matched slave_ready is high, the block SHALL drive master_ready[granted]=1 and master_data_o=slave_data_i[matched] in the same cycle, then return to IDLE on the next edge.
REQ-030 Best-case latency SHALL be: request at cycle N, slave_enable at N+1, master_ready at N+1 if the slave answers in the same cycle.
REQ-031 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready.
REQ-032 When the wait counter reaches TIMEOUT, the block SHALL drop slave_enable and go to ERR.
REQ-033 If the granted master drops master_enable in BUSY, the block SHALL abort to IDLE with no ready and no error.
REQ-034 Slave ready from a non-selected slave SHALL be ignored.
REQ-035 master_ready and master_error SHALL never both be high, and SHALL never be high for a non-granted master.
REQ-036 master_data_o SHALL be 32'h0 when not completing a read.
REQ-037 Back-to-back grants: after a completion, the next grant SHALL occur no sooner than one IDLE cycle later.

Reset
REQ-038 While rst is high: state = IDLE; wait counter = 0; last grant = NMASTERS-1; all slave_enable, master_ready and master_error = 0; master_data_o = 0.
REQ-039 When rst asserts mid-transaction, the transaction SHALL be dropped with no completion pulse, and the block SHALL restart in IDLE on the first cycle after rst falls.

Verification
REQ-040 Single read: M0 reads 0x0000_0010, slave0 ready after 2 cycles with 0xCAFE_F00D -> slave_enable=001 for 3 cycles; master_ready=001 for 1 cycle; master_data_o=0xCAFE_F00D.
REQ-041 Unmapped access: M1 writes 0x2000_0000 -> slave_enable stays 000; master_error=010 for one cycle, 2 cycles after the request.
REQ-042 Round-robin: M0, M1 and M2 request continuously, with slaves ready immediately -> grant order M0, M1, M2, M0; with ARB_MODE 0 -> M0 every time.
REQ-043 Timeout: TIMEOUT=4, slave1 never ready, M0 reads 0x1000_0004 -> slave_enable=010 for 4 cycles, then master_error=001.
REQ-044 Abort and reset: M2 drops enable in BUSY -> IDLE with no pulses; rst during BUSY -> all outputs 0 next cycle, and a new request after release is served normally.
REQ-045 Alias priority: address 0x1100_0000 matching both slave 2 and an overlapping mask on slave 1 -> the lower index (slave 1) is selected.
